// File: rtl/lsu_bus_adapter.sv
// Load/store adapter between the core's execute-stage memory command and a
// valid/ready request bus with a separate response channel. Stalls the core
// while an access is outstanding and reports misaligned, illegal, bus-error
// and timeout faults.
module lsu_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        lsu_fault,
    output logic [1:0]  fault_code,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        fault_q;
    logic [1:0]  fcode_q;
    logic [31:0] rdata_q;
    logic        req_valid_q;

    logic        access, illegal, misaligned, idle_fault, idle_start;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_ext;

    // Sign/zero-extend the selected byte or halfword of a returned read word.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'b0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'b0, h};
            default: extend = w;
        endcase
    endfunction

    // Decode the incoming command: legality, alignment and store lanes.
    always_comb begin
        access     = MemRead | MemWrite;
        illegal    = (MemRead & MemWrite)
                   | (MemRead & !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                   | (MemWrite & !(funct3 inside {3'b000, 3'b001, 3'b010}));
        misaligned = ((funct3[1:0] == 2'b01) & address[0])
                   | ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
        idle_fault = (state_q == StIdle) & access & (illegal | misaligned);
        idle_start = (state_q == StIdle) & access & !illegal & !misaligned;
        wstrb_new  = 4'b0000;
        wdata_new  = write_data;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_new = 4'b0001 << address[1:0];
                    wdata_new = {4{write_data[7:0]}};
                end
                2'b01: begin
                    wstrb_new = address[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{write_data[15:0]}};
                end
                default: wstrb_new = 4'b1111;
            endcase
        end
        rdata_ext = extend(bus_rdata, off_q, f3_q);
    end

    // Access FSM with registered bus outputs, load data and deferred fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            fault_q     <= 1'b0;
            fcode_q     <= 2'b00;
            rdata_q     <= 32'd0;
            req_valid_q <= 1'b0;
            bus_addr    <= 32'd0;
            bus_we      <= 1'b0;
            bus_wstrb   <= 4'b0000;
            bus_wdata   <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    fault_q <= 1'b0;
                    if (idle_fault) begin
                        rdata_q <= 32'd0;
                    end else if (idle_start) begin
                        off_q       <= address[1:0];
                        f3_q        <= funct3;
                        bus_addr    <= {address[31:2], 2'b00};
                        bus_we      <= MemWrite;
                        bus_wstrb   <= wstrb_new;
                        bus_wdata   <= wdata_new;
                        req_valid_q <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= 8'd0;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (bus_rsp_valid) begin
                        state_q <= StDone;
                        cnt_q   <= 8'd0;
                        if (bus_err) begin
                            fault_q <= 1'b1;
                            fcode_q <= 2'b11;
                            rdata_q <= 32'd0;
                        end else if (!bus_we) begin
                            rdata_q <= rdata_ext;
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        state_q <= StDone;
                        cnt_q   <= 8'd0;
                        fault_q <= 1'b1;
                        fcode_q <= 2'b11;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    fault_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Core-facing outputs; decode faults retire in the same cycle they appear.
    always_comb begin
        stall         = idle_start | (state_q == StReq) | (state_q == StRsp);
        lsu_fault     = idle_fault | ((state_q == StDone) & fault_q);
        fault_code    = 2'b00;
        if (idle_fault) begin
            fault_code = illegal ? 2'b10 : 2'b01;
        end else if ((state_q == StDone) & fault_q) begin
            fault_code = fcode_q;
        end
        read_data     = idle_fault ? 32'd0 : rdata_q;
        // Drop the request as soon as reset is seen rather than a cycle later.
        bus_req_valid = req_valid_q & !rst;
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Self-checking bench for lsu_bus_adapter with a retire scoreboard.
module tb_lsu_bus_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] address, write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        stall, lsu_fault;
    logic [1:0]  fault_code;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];

    lsu_bus_adapter #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .address      (address),
        .write_data   (write_data),
        .funct3       (funct3),
        .read_data    (read_data),
        .stall        (stall),
        .lsu_fault    (lsu_fault),
        .fault_code   (fault_code),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Retire monitor: a command is retired when it is presented and stall is low.
    always @(negedge clk) begin
        if (!rst && (MemRead || MemWrite) && !stall) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_retire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_rd) check_eq("read_data", read_data, e.rd);
                check_eq("lsu_fault", {31'd0, lsu_fault}, {31'd0, e.fault});
                check_eq("fault_code", {30'd0, fault_code}, {30'd0, e.code});
            end
        end
    end

    // Drive one command, play the bus slave and count stall cycles.
    // rsp_mode: 0 good response, 1 bus error, 2 never respond.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int ready_wait, input int rsp_mode,
                             input logic [31:0] rdata, input logic [31:0] exp_rd,
                             input logic chk_rd, input logic exp_fault,
                             input logic [1:0] exp_code, input int exp_stall);
        exp_t        e;
        int          stalls, waited, guard;
        logic        in_rsp;
        logic [3:0]  strb;
        logic [31:0] wdat;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_strb;
        logic        p_we;
        e.rd = exp_rd; e.chk_rd = chk_rd; e.fault = exp_fault; e.code = exp_code;
        exp_q.push_back(e);
        strb = 4'b0000;
        wdat = wd;
        if (wr) begin
            case (f3[1:0])
                2'b00:   begin strb = 4'b0001 << addr[1:0]; wdat = {4{wd[7:0]}}; end
                2'b01:   begin strb = addr[1] ? 4'b1100 : 4'b0011; wdat = {2{wd[15:0]}}; end
                default: strb = 4'b1111;
            endcase
        end
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; address = addr; write_data = wd; funct3 = f3;
        stalls = 0; waited = 0; guard = 0; in_rsp = 1'b0;
        p_addr = '0; p_wdata = '0; p_strb = '0; p_we = 1'b0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (!stall) break;
            stalls++;
            if (in_rsp) begin
                bus_req_ready = 1'b0;
                bus_rsp_valid = (rsp_mode != 2);
                bus_err       = (rsp_mode == 1);
                bus_rdata     = rdata;
            end else if (bus_req_valid) begin
                if (waited == 0) begin
                    check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
                    check_eq("bus_we", {31'd0, bus_we}, {31'd0, wr});
                    check_eq("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, strb});
                    if (wr) check_eq("bus_wdata", bus_wdata, wdat);
                end else begin
                    check_eq("hold_addr", bus_addr, p_addr);
                    check_eq("hold_wdata", bus_wdata, p_wdata);
                    check_eq("hold_ctl", {27'd0, bus_we, bus_wstrb}, {27'd0, p_we, p_strb});
                end
                p_addr = bus_addr; p_wdata = bus_wdata; p_strb = bus_wstrb; p_we = bus_we;
                if (waited >= ready_wait) begin
                    bus_req_ready = 1'b1;
                    in_rsp = 1'b1;
                end else begin
                    waited++;
                end
            end
        end
        if (guard >= 200) check_eq("retire_timeout", 32'd0, 32'd1);
        check_eq("no_req_at_retire", {31'd0, bus_req_valid}, 32'd0);
        if (exp_stall >= 0) check_eq("stall_cycles", stalls, exp_stall);
        #2;
        MemRead = 1'b0; MemWrite = 1'b0; bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0; bus_err = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; address = '0; write_data = '0; funct3 = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_fault", {30'd0, lsu_fault, bus_req_valid}, 32'd0);
        check_eq("rst_read_data", read_data, 32'd0);
        check_eq("rst_bus", {26'd0, fault_code, bus_wstrb}, 32'd0);

        // Loads: width/sign extension
        do_access(1, 0, 32'h0000_1004, 0, 3'b010, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_1003, 0, 3'b000, 0, 0, 32'h80FF_0000, 32'hFFFF_FF80, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_1003, 0, 3'b100, 0, 0, 32'h80FF_0000, 32'h0000_0080, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_1002, 0, 3'b001, 0, 0, 32'h80FF_0000, 32'hFFFF_80FF, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_1002, 0, 3'b101, 0, 0, 32'h80FF_0000, 32'h0000_80FF, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_1000, 0, 3'b001, 0, 0, 32'h1234_7F01, 32'h0000_7F01, 1, 0, 2'b00, 3);

        // Stores: lanes, strobes and a slow-ready hold
        do_access(0, 1, 32'h0000_2001, 32'h0000_00A5, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 3);
        do_access(0, 1, 32'h0000_2002, 32'h0000_1234, 3'b001, 5, 0, 0, 0, 0, 0, 2'b00, 8);
        do_access(0, 1, 32'h0000_2000, 32'hCAFE_F00D, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 3);

        // Decode faults retire in the same cycle, illegal beats misaligned
        do_access(1, 0, 32'h0000_3002, 0, 3'b010, 0, 0, 0, 0, 1, 1, 2'b01, 0);
        do_access(0, 1, 32'h0000_3001, 32'h55, 3'b001, 0, 0, 0, 0, 1, 1, 2'b01, 0);
        do_access(1, 1, 32'h0000_3000, 0, 3'b010, 0, 0, 0, 0, 1, 1, 2'b10, 0);
        do_access(1, 0, 32'h0000_3003, 0, 3'b011, 0, 0, 0, 0, 1, 1, 2'b10, 0);
        do_access(0, 1, 32'h0000_3000, 0, 3'b100, 0, 0, 0, 0, 1, 1, 2'b10, 0);

        // Timeout and bus error, each preceded by a load that leaves nonzero data
        do_access(1, 0, 32'h0000_4000, 0, 3'b010, 0, 0, 32'h1122_3344, 32'h1122_3344, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_4000, 0, 3'b010, 0, 2, 0, 0, 1, 1, 2'b11, 6);
        do_access(1, 0, 32'h0000_4004, 0, 3'b010, 0, 0, 32'h5566_7788, 32'h5566_7788, 1, 0, 2'b00, 3);
        do_access(1, 0, 32'h0000_4008, 0, 3'b010, 0, 1, 32'hFFFF_FFFF, 0, 1, 1, 2'b11, 3);
        do_access(1, 0, 32'h0000_400C, 0, 3'b010, 0, 0, 32'h55AA_55AA, 32'h55AA_55AA, 1, 0, 2'b00, 3);

        // Reset while waiting in RSP, then a stale response
        @(posedge clk); #1;
        MemRead = 1'b1; address = 32'h0000_5000; funct3 = 3'b010;
        @(negedge clk);                      // IDLE
        @(negedge clk);                      // REQ
        check_eq("rstmid_req_valid", {31'd0, bus_req_valid}, 32'd1);
        bus_req_ready = 1'b1;
        @(negedge clk);                      // RSP
        check_eq("rstmid_in_rsp", {31'd0, stall}, 32'd1);
        bus_req_ready = 1'b0;
        rst = 1'b1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_rsp_valid = 1'b1; bus_rdata = 32'h9999_9999;
        @(negedge clk);
        check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
        check_eq("rstmid_read_data", read_data, 32'd0);
        @(negedge clk);
        check_eq("rstmid_ignored", {29'd0, stall, lsu_fault, bus_req_valid}, 32'd0);
        check_eq("rstmid_read_data2", read_data, 32'd0);
        bus_rsp_valid = 1'b0;
        do_access(1, 0, 32'h0000_5004, 0, 3'b010, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0, 2'b00, 3);

        repeat (2) @(posedge clk);
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit sitting directly downstream of the single-cycle core's execute stage; replaces its direct data-memory hookup.
- Takes the core's per-instruction memory command: MemRead/MemWrite, ALU address, rs2 data, funct3.
- Drives a valid/ready request + response data bus, returns sign/zero-extended load data, and stalls the core while the access is outstanding.
- Flags misaligned, illegal-width, bus-error and timeout faults.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waited in RSP before the access is aborted with a timeout fault; 8-bit counter sized to fit.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high
- MemRead  input  1  core load command, held stable while stall=1
- MemWrite  input  1  core store command, held stable while stall=1
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (rs2)
- funct3  input  3  access width/sign
- read_data  output  32  extended load data, valid when stall=0 on a load
- stall  output  1  freeze PC/regfile write while high
- lsu_fault  output  1  access retired with fault (this cycle only)
- fault_code  output  2  01 misaligned, 10 illegal funct3 / both commands, 11 bus error or timeout
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  request accepted
- bus_addr  output  32  word-aligned address ({address[31:2],2'b00})
- bus_we  output  1  1=write
- bus_wstrb  output  4  byte enables (writes); 0000 on reads
- bus_wdata  output  32  lane-replicated store data
- bus_rsp_valid  input  1  response/ack valid (reads and writes)
- bus_rdata  input  32  read word
- bus_err  input  1  qualifies bus_rsp_valid as error

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. Reset → IDLE; all registered outputs 0, timeout counter 0, read_data 0.
- IDLE:
  - access = MemRead|MemWrite.
  - If access and legal: latch addr[1:0], funct3, we, wstrb, wdata, bus_addr; go to REQ.
  - Illegal cases: MemRead&MemWrite both high, load funct3 ∉{000,001,010,100,101}, store funct3 ∉{000,001,010}. Each gives fault 10.
  - Misaligned cases: halfword with addr[0]=1, word with addr[1:0]≠00. Each gives fault 01.
  - Fault handling is combinational in the same cycle: stall=0, lsu_fault=1, read_data=0, no bus request, stay IDLE.
  - Illegal takes priority over misaligned.
- stall = (IDLE & access & legal & aligned) | REQ | RSP. DONE has stall=0, so the core retires there.
- REQ:
  - bus_req_valid=1 with all bus_* held constant until bus_req_ready; then go to RSP.
  - No timeout in REQ (never drop valid before handshake).
- RSP:
  - bus_rsp_valid is sampled only in RSP; any response in IDLE, REQ or DONE is ignored.
  - Counter increments each RSP cycle.
  - On rsp_valid & !bus_err: go to DONE. A load captures bus_rdata, extended per latched funct3/offset.
  - On rsp_valid & bus_err, or counter == TIMEOUT_CYCLES-1 without a response: go to DONE with fault 11, read_data 0.
  - Counter clears on entering DONE.
- DONE: exactly one cycle. stall=0, read_data valid (loads), lsu_fault/fault_code valid if faulted. Then → IDLE.
- Store lane rules:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: wstrb = 0011 (addr[1]=0) or 1100, wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111, wdata = wd.
- Load extension:
  - LB/LBU select byte addr[1:0], sign/zero extend.
  - LH/LHU select half addr[1], sign/zero extend.
  - LW passes the word through.
- read_data holds its value outside DONE and fault cycles (0 after reset or any fault).
- Minimum latency, zero-wait bus (ready in REQ, rsp first RSP cycle): IDLE→REQ→RSP→DONE = 4 cycles, stall high 3 cycles.
- Reset mid-operation: any state → IDLE next edge, bus_req_valid drops immediately, stale responses ignored.
- No access (both commands low): outputs idle, stall=0, lsu_fault=0.

Test Plan:
- Zero-wait LW to 0x0000_1004, bus_rdata=0xDEADBEEF → REQ addr 0x1004 wstrb 0000, stall high exactly 3 cycles, read_data=0xDEADBEEF in DONE.
- LB at 0x1003 returning 0x80FF_0000, then LBU at the same address → 0xFFFFFF80, then 0x00000080; LH at 0x1002 → 0xFFFF80FF.
- SB at 0x2001 with wd=0x000000A5 → wstrb 0010, wdata 0xA5A5A5A5; SH at 0x2002 wd=0x1234 → wstrb 1100, wdata 0x12341234; ready held low 5 cycles → valid and all bus_* stable throughout.
- LW at 0x3002 and SH at 0x3001 → no bus_req_valid, stall=0, lsu_fault=1, fault_code=01 same cycle. MemRead&MemWrite both high, or funct3=011 load → fault_code=10.
- Fault paths:
  - TIMEOUT_CYCLES=4, no response → DONE after 4 RSP cycles, fault 11, read_data 0.
  - rsp_valid with bus_err=1 → fault 11.
- Reset asserted in RSP, followed by bus_rsp_valid next cycle → IDLE, response ignored, stall=0, read_data=0, then a new LW completes normally.
